// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared width helper and 50 MHz timing defaults for the button front end
package btn_pkg;

  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_HOLD_CYCLES     = 50_000_000;
  localparam int DEF_REPEAT_CYCLES   = 10_000_000;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// rtl/btn_debounce_ch.sv - one button channel: synchroniser, debounce, press/release pulses
// Optional hold-to-repeat when BTN_AUTO_REPEAT_EN is defined.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit ACTIVE_LOW      = 1'b0,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int              CNT_W    = idx_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 1 || REPEAT_CYCLES > HOLD_CYCLES) begin : g_bad_params
    $error("btn_debounce_ch: illegal timing parameters");
  end

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             flip;
  logic             rpt_hit;

  assign flip = (s2 != level) && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      s1 <= raw ^ ACTIVE_LOW;
      s2 <= s1;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  localparam int               HOLD_W      = idx_w(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - REPEAT_CYCLES);

  logic [HOLD_W-1:0] hold_cnt;

  // A release edge wins over a coincident repeat.
  assign rpt_hit = level && !flip && (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk) begin
    if (rst || flip || !level) begin
      hold_cnt <= '0;
    end else if (rpt_hit) begin
      hold_cnt <= HOLD_RELOAD;
    end else begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  assign rpt_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= (flip && s2) || rpt_hit;
      release_pulse <= flip && !s2;
    end
  end

endmodule

// File: rtl/btn_debounce_array.sv
// rtl/btn_debounce_array.sv - N_CH debounced buttons with press/release pulses and lowest-index encoder
// Optional auto-repeat build: BTN_AUTO_REPEAT_EN.
module btn_debounce_array
  import btn_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit ACTIVE_LOW      = 1'b0,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          btn_in,
  output logic [N_CH-1:0]          btn_level,
  output logic [N_CH-1:0]          btn_press,
  output logic [N_CH-1:0]          btn_release,
  output logic                     any_press,
  output logic [idx_w(N_CH)-1:0]   press_idx
);

  localparam int IDX_W = idx_w(N_CH);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .raw           (btn_in[i]),
      .level         (btn_level[i]),
      .press_pulse   (btn_press[i]),
      .release_pulse (btn_release[i])
    );
  end

  assign any_press = |btn_press;

  // Scan downward so the lowest set index is the last assignment.
  always_comb begin
    press_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (btn_press[i]) press_idx = IDX_W'(i);
    end
  end

endmodule

// File: tb/tb_btn_debounce_array.sv
// tb/tb_btn_debounce_array.sv - directed and random checks of btn_debounce_array against a window model
module tb_btn_debounce_array;

  localparam int N    = 4;
  localparam int D    = 4;
  localparam int HOLD = 10;
  localparam int REP  = 4;
  localparam bit AL   = 1'b0;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn_in;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic         any_press;
  logic [1:0]   press_idx;

  always #5 clk = ~clk;

  btn_debounce_array #(
    .N_CH            (N),
    .DEBOUNCE_CYCLES (D),
    .ACTIVE_LOW      (AL),
    .HOLD_CYCLES     (HOLD),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_in      (btn_in),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .any_press   (any_press),
    .press_idx   (press_idx)
  );

  int n_checks = 0;
  int n_fail   = 0;

  bit p1 [N];
  bit p2 [N];
  bit lvl_m [N];
  bit prs_m [N];
  bit rel_m [N];
  int held [N];
  bit hist [N][$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Level flips once the last D synchronised samples all disagree with it.
  task automatic model_edge();
    for (int c = 0; c < N; c++) begin
      prs_m[c] = 1'b0;
      rel_m[c] = 1'b0;
      if (rst) begin
        p1[c] = 1'b0;
        p2[c] = 1'b0;
        lvl_m[c] = 1'b0;
        held[c] = 0;
        hist[c].delete();
      end else begin
        bit s;
        bit all_diff;
        s = p2[c];
        p2[c] = p1[c];
        p1[c] = btn_in[c] ^ AL;
        hist[c].push_back(s);
        if (hist[c].size() > D) void'(hist[c].pop_front());
        all_diff = (hist[c].size() == D);
        foreach (hist[c][k]) if (hist[c][k] == lvl_m[c]) all_diff = 1'b0;
        if (all_diff) begin
          lvl_m[c] = s;
          hist[c].delete();
          held[c] = 0;
          if (s) prs_m[c] = 1'b1;
          else   rel_m[c] = 1'b1;
        end else if (lvl_m[c]) begin
          held[c]++;
`ifdef BTN_AUTO_REPEAT_EN
          if (held[c] == HOLD || (held[c] > HOLD && (held[c] - HOLD) % REP == 0))
            prs_m[c] = 1'b1;
`endif
        end
      end
    end
  endtask

  task automatic compare();
    logic [N-1:0] lv, pv, rv;
    logic [1:0]   iv;
    iv = 2'd0;
    for (int c = N - 1; c >= 0; c--) begin
      lv[c] = lvl_m[c];
      pv[c] = prs_m[c];
      rv[c] = rel_m[c];
      if (prs_m[c]) iv = 2'(c);
    end
    chk("level", btn_level, lv);
    chk("press", btn_press, pv);
    chk("release", btn_release, rv);
    chk("any_press", any_press, |pv);
    chk("press_idx", press_idx, iv);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  initial begin
    int bseq [7] = '{1, 1, 0, 1, 1, 1, 0};
    int cnt_a, at_a, cnt_b, at_b, t0;

    // 1: button held through reset
    rst = 1'b1;
    btn_in = 4'b1111;
    repeat (3) begin
      step();
      chk("t1_rst_level", btn_level, 4'b0000);
      chk("t1_rst_press", btn_press, 4'b0000);
    end
    rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      if (k == 5) begin
        chk("t1_press", btn_press, 4'b1111);
        chk("t1_level", btn_level, 4'b1111);
        chk("t1_any", any_press, 1'b1);
        chk("t1_idx", press_idx, 2'd0);
      end else begin
        chk("t1_quiet", btn_press, 4'b0000);
      end
    end

    // 2: bounce on ch0
    btn_in = 4'b0000;
    repeat (8) step();
    cnt_a = 0;
    at_a = -1;
    for (int k = 0; k < 16; k++) begin
      btn_in[0] = (k < 7) ? bseq[k][0] : 1'b1;
      step();
      if (btn_press[0]) begin
        cnt_a++;
        at_a = k;
      end
      if (k < 11) chk("t2_level_hold", btn_level[0], 1'b0);
    end
    chk("t2_press_count", cnt_a, 1);
    chk("t2_press_edge", at_a, 12);

    // 3: release on ch2
    btn_in[2] = 1'b1;
    repeat (8) step();
    chk("t3_level_up", btn_level[2], 1'b1);
    btn_in[2] = 1'b0;
    cnt_a = 0;
    at_a = -1;
    cnt_b = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (btn_release[2]) begin
        cnt_a++;
        at_a = k;
      end
      if (btn_press[2]) cnt_b++;
    end
    chk("t3_rel_count", cnt_a, 1);
    chk("t3_rel_edge", at_a, 5);
    chk("t3_no_press", cnt_b, 0);
    chk("t3_level_down", btn_level[2], 1'b0);

    // 4: simultaneous ch1/ch3
    btn_in = 4'b0000;
    repeat (8) step();
    btn_in = 4'b1010;
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 5) begin
        chk("t4_press", btn_press, 4'b1010);
        chk("t4_any", any_press, 1'b1);
        chk("t4_idx", press_idx, 2'd1);
      end else begin
        chk("t4_quiet", btn_press, 4'b0000);
      end
    end

    // 5: reset mid-count
    btn_in = 4'b0000;
    repeat (8) step();
    btn_in[0] = 1'b1;
    repeat (5) step();
    rst = 1'b1;
    step();
    chk("t5_rst_level", btn_level, 4'b0000);
    chk("t5_rst_press", btn_press, 4'b0000);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 5) chk("t5_press", btn_press, 4'b0001);
      else        chk("t5_quiet", btn_press, 4'b0000);
    end

    // 6: long hold on ch0, released so the release lands on a repeat slot
    btn_in = 4'b0000;
    repeat (8) step();
    btn_in[0] = 1'b1;
    t0 = -1;
    cnt_a = 0;
    at_b = -1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (btn_press[0]) begin
        cnt_a++;
        if (t0 < 0) t0 = k;
      end
      if (btn_release[0]) at_b = k;
      if (t0 >= 0 && k == t0 + 16) btn_in[0] = 1'b0;
    end
    chk("t6_t0", t0, 5);
`ifdef BTN_AUTO_REPEAT_EN
    chk("t6_press_count", cnt_a, 4);
`else
    chk("t6_press_count", cnt_a, 1);
`endif
    chk("t6_release_edge", at_b, 27);

    // random traffic with occasional resets
    for (int k = 0; k < 1500; k++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 7) == 0) btn_in[c] = ~btn_in[c];
      end
      rst = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
